// File: rtl/prover_compute_v_encollect_cnt.sv
// prover_compute_v_encollect_cnt: counting enable collector for the compute_v stage.
// Define ENCOLLECT_OUTREG_EN to add a second output register stage (latency 2).
module prover_compute_v_encollect_cnt #(
   parameter int ninputs   = 8,
   parameter int nParallel = 16,
   parameter int depth     = 4,
   parameter int cntBits   = $clog2(depth + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [nParallel-1:0] en_in [ninputs],
   input  logic [ninputs-1:0]   in_mask,
   input  logic                 clr,
   output logic [nParallel-1:0] en_out,
   output logic [nParallel-1:0] overflow
);

   localparam logic [cntBits-1:0] CNT_MAX = cntBits'(depth);
   localparam logic [cntBits-1:0] CNT_ONE = cntBits'(1);

   if (depth < 1) begin : g_bad_depth
      $error("depth must be >= 1");
   end

   logic [cntBits-1:0]   cnt      [ninputs][nParallel];
   logic [cntBits-1:0]   cnt_next [ninputs][nParallel];
   logic [ninputs-1:0]   vote     [nParallel];
   logic [nParallel-1:0] fire;
   logic [nParallel-1:0] drop;
   logic                 any_mask;

   assign any_mask = |in_mask;

   // A producer votes for a lane when it is ignored or has a pulse to give.
   always_comb begin
      for (int j = 0; j < nParallel; j++) begin
         for (int k = 0; k < ninputs; k++) begin
            vote[j][k] = ~in_mask[k]
                       | (cnt[k][j] != '0)
                       | en_in[k][j];
         end
      end
   end

   always_comb begin
      fire = '0;
      for (int j = 0; j < nParallel; j++) begin
         fire[j] = any_mask & (&vote[j]);
      end
   end

   // Pulse-and-fire in the same cycle leaves the count untouched.
   always_comb begin
      drop = '0;
      for (int k = 0; k < ninputs; k++) begin
         for (int j = 0; j < nParallel; j++) begin
            cnt_next[k][j] = cnt[k][j];
            if (!in_mask[k]) begin
               cnt_next[k][j] = '0;
            end else if (fire[j]) begin
               if (!en_in[k][j]) begin
                  cnt_next[k][j] = cnt[k][j] - CNT_ONE;
               end
            end else if (en_in[k][j]) begin
               if (cnt[k][j] == CNT_MAX) begin
                  drop[j] = 1'b1;
               end else begin
                  cnt_next[k][j] = cnt[k][j] + CNT_ONE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < ninputs; k++) begin
            for (int j = 0; j < nParallel; j++) begin
               cnt[k][j] <= '0;
            end
         end
      end else if (clr) begin
         for (int k = 0; k < ninputs; k++) begin
            for (int j = 0; j < nParallel; j++) begin
               cnt[k][j] <= '0;
            end
         end
      end else begin
         for (int k = 0; k < ninputs; k++) begin
            for (int j = 0; j < nParallel; j++) begin
               cnt[k][j] <= cnt_next[k][j];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= '0;
      end else if (clr) begin
         overflow <= '0;
      end else begin
         overflow <= overflow | drop;
      end
   end

`ifdef ENCOLLECT_OUTREG_EN
   logic [nParallel-1:0] stage1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage1 <= '0;
         en_out <= '0;
      end else if (clr) begin
         stage1 <= '0;
         en_out <= '0;
      end else begin
         stage1 <= fire;
         en_out <= stage1;
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_out <= '0;
      end else if (clr) begin
         en_out <= '0;
      end else begin
         en_out <= fire;
      end
   end
`endif

endmodule

// File: tb/tb_prover_compute_v_encollect_cnt.sv
// tb_prover_compute_v_encollect_cnt: directed checks of the enable collector.
// Handles both output latencies (ENCOLLECT_OUTREG_EN defined or not).
module tb_prover_compute_v_encollect_cnt;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [7:0]  in_mask;
   logic [15:0] en_in [8];
   logic [15:0] en_out;
   logic [15:0] overflow;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] pend  = '0;

   always #5 clk = ~clk;

   prover_compute_v_encollect_cnt dut (
      .clk      (clk),
      .rst      (rst),
      .en_in    (en_in),
      .in_mask  (in_mask),
      .clr      (clr),
      .en_out   (en_out),
      .overflow (overflow)
   );

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one cycle of pulses; e is the fire value this cycle produces.
   task automatic cyc(input logic [7:0] who, input logic [15:0] lanes,
                      input logic [15:0] e, input string tag);
      logic [15:0] want;
      for (int k = 0; k < 8; k++) en_in[k] = who[k] ? lanes : 16'h0;
      @(posedge clk);
      #1;
`ifdef ENCOLLECT_OUTREG_EN
      want = pend;
      pend = e;
`else
      want = e;
`endif
      chk(tag, en_out, want);
      for (int k = 0; k < 8; k++) en_in[k] = 16'h0;
   endtask

   task automatic do_clr(input string tag);
      clr = 1'b1;
      for (int k = 0; k < 8; k++) en_in[k] = 16'hFFFF;
      @(posedge clk);
      #1;
      clr = 1'b0;
      for (int k = 0; k < 8; k++) en_in[k] = 16'h0;
      pend = '0;
      chk({tag, "_en"}, en_out, 16'h0);
      chk({tag, "_ovf"}, overflow, 16'h0);
   endtask

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      in_mask = 8'hFF;
      for (int k = 0; k < 8; k++) en_in[k] = 16'h0;
      @(posedge clk);
      #1;
      chk("rst_en", en_out, 16'h0);
      chk("rst_ovf", overflow, 16'h0);
      rst = 1'b0;

      // all producers together on lane 3
      cyc(8'h00, 16'h0000, 16'h0000, "t1_pre");
      cyc(8'hFF, 16'h0008, 16'h0008, "t1_fire");
      cyc(8'h00, 16'h0000, 16'h0000, "t1_idle0");
      cyc(8'h00, 16'h0000, 16'h0000, "t1_idle1");
      cyc(8'h01, 16'h0008, 16'h0000, "t1_cnt0");
      cyc(8'h00, 16'h0000, 16'h0000, "t1_idle2");
      do_clr("t1_clr");

      // staggered producers on lane 0
      for (int k = 0; k < 8; k++)
         cyc(8'(1 << k), 16'h0001, (k == 7) ? 16'h0001 : 16'h0000, "t2_stag");
      cyc(8'h00, 16'h0000, 16'h0000, "t2_idle0");
      cyc(8'h00, 16'h0000, 16'h0000, "t2_idle1");

      // producer 0 runs ahead on lane 1
      for (int i = 0; i < 3; i++) cyc(8'h01, 16'h0002, 16'h0000, "t3_ahead");
      cyc(8'h00, 16'h0000, 16'h0000, "t3_gap");
      for (int i = 0; i < 3; i++) cyc(8'hFE, 16'h0002, 16'h0002, "t3_fire");
      cyc(8'h00, 16'h0000, 16'h0000, "t3_idle0");
      cyc(8'h00, 16'h0000, 16'h0000, "t3_idle1");
      chk("t3_ovf", overflow, 16'h0000);

      // saturation of producer 2 on lane 5
      for (int i = 0; i < 4; i++) cyc(8'h04, 16'h0020, 16'h0000, "t4_fill");
      chk("t4_ovf_pre", overflow, 16'h0000);
      cyc(8'h04, 16'h0020, 16'h0000, "t4_drop0");
      chk("t4_ovf_set", overflow, 16'h0020);
      cyc(8'h04, 16'h0020, 16'h0000, "t4_drop1");
      chk("t4_ovf_hold", overflow, 16'h0020);
      for (int i = 0; i < 4; i++) cyc(8'hFB, 16'h0020, 16'h0020, "t4_drain");
      cyc(8'hFB, 16'h0020, 16'h0000, "t4_empty");
      cyc(8'h00, 16'h0000, 16'h0000, "t4_idle");
      chk("t4_ovf_sticky", overflow, 16'h0020);
      do_clr("t4_clr");
      cyc(8'hFB, 16'h0020, 16'h0000, "t4_cnt_clr");
      cyc(8'h00, 16'h0000, 16'h0000, "t4_idle1");
      do_clr("t4_clr2");

      // runtime mask
      in_mask = 8'h0F;
      cyc(8'h0F, 16'h0080, 16'h0080, "t5_part");
      in_mask = 8'h00;
      cyc(8'hFF, 16'h0080, 16'h0000, "t5_none0");
      cyc(8'hFF, 16'hFFFF, 16'h0000, "t5_none1");
      in_mask = 8'hFF;
      cyc(8'h02, 16'h0080, 16'h0000, "t5_p1a");
      cyc(8'h02, 16'h0080, 16'h0000, "t5_p1b");
      in_mask = 8'hFD;
      cyc(8'h00, 16'h0000, 16'h0000, "t5_unmask");
      in_mask = 8'hFF;
      cyc(8'hFD, 16'h0080, 16'h0000, "t5_discard");
      cyc(8'h00, 16'h0000, 16'h0000, "t5_idle");
      chk("t5_ovf", overflow, 16'h0000);
      do_clr("t5_clr");

      // async reset mid-set
      for (int i = 0; i < 5; i++) cyc(8'h01, 16'h0010, 16'h0000, "t6_sat");
      chk("t6_ovf", overflow, 16'h0010);
      cyc(8'h0F, 16'h0004, 16'h0000, "t6_part");
      cyc(8'hFF, 16'h0008, 16'h0008, "t6_fire");
      #3;
      rst = 1'b1;
      #1;
      chk("t6_rst_en", en_out, 16'h0000);
      chk("t6_rst_ovf", overflow, 16'h0000);
      #1;
      rst = 1'b0;
      pend = '0;
      cyc(8'hF0, 16'h0004, 16'h0000, "t6_lane2");
      cyc(8'hFE, 16'h0010, 16'h0000, "t6_lane4");
      cyc(8'h00, 16'h0000, 16'h0000, "t6_idle0");
      cyc(8'h00, 16'h0000, 16'h0000, "t6_idle1");
      chk("t6_ovf_after", overflow, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
